// File: rtl/cam_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cam_pkg                                                         |
// | Purpose  : Shared types and default sizes for the CAM request sequencer.   |
// |            cam_op_e    - command encoding carried on req_op_i / rsp_op_o   |
// |            cam_state_e - sequencer FSM states                             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package cam_pkg;

  localparam int CAM_WIDTH      = 32;
  localparam int CAM_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    CAM_READ       = 2'd0,
    CAM_WRITE      = 2'd1,
    CAM_SEARCH     = 2'd2,
    CAM_INVALIDATE = 2'd3
  } cam_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } cam_state_e;

endpackage
`default_nettype wire

// File: rtl/cam_prio_enc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cam_prio_enc                                                    |
// | Purpose  : Combinational lowest-index priority encoder.                    |
// | Ports    : vec_i   [DEPTH]      - request vector                           |
// |            found_o              - any bit of vec_i set                     |
// |            index_o [ADDR_WIDTH] - index of the lowest set bit, 0 if none   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module cam_prio_enc #(
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]      vec_i,
  output logic                  found_o,
  output logic [ADDR_WIDTH-1:0] index_o
);

  always_comb begin
    found_o = |vec_i;
    index_o = '0;
    // Scan from the top down so the last assignment is the lowest set bit.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        index_o = ADDR_WIDTH'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cam_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cam_ctrl                                                        |
// | Purpose  : One-at-a-time request sequencer in front of the CAM decoder.    |
// |            Accepts READ/WRITE/SEARCH/INVALIDATE, pulses the matching       |
// |            decoder enable for one cycle, captures array data or match      |
// |            lines a cycle later and returns a response. Owns the per-entry  |
// |            valid bits so searches only hit written entries.               |
// | Ports    : clk_i, rst_n_i (async, active-low)                              |
// |            req_*   - command port (valid/ready)                            |
// |            rsp_*   - response port (valid/ready)                           |
// |            read_*/write_*/search_* - decoder controls                      |
// |            array_read_data_i, array_match_i - array results                |
// |            entry_valid_o - per-entry valid bits                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module cam_ctrl
  import cam_pkg::*;
#(
  parameter int WIDTH      = CAM_WIDTH,
  parameter int ADDR_WIDTH = CAM_ADDR_WIDTH,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [1:0]            req_op_i,
  input  logic [ADDR_WIDTH-1:0] req_index_i,
  input  logic [WIDTH-1:0]      req_data_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [1:0]            rsp_op_o,
  output logic                  rsp_hit_o,
  output logic [ADDR_WIDTH-1:0] rsp_index_o,
  output logic [WIDTH-1:0]      rsp_data_o,
  output logic                  read_enable_o,
  output logic [ADDR_WIDTH-1:0] read_index_o,
  output logic                  write_enable_o,
  output logic [ADDR_WIDTH-1:0] write_index_o,
  output logic                  search_enable_o,
  output logic [WIDTH-1:0]      search_data_o,
  input  logic [WIDTH-1:0]      array_read_data_i,
  input  logic [DEPTH-1:0]      array_match_i,
  output logic [DEPTH-1:0]      entry_valid_o
);

  cam_state_e            state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  cam_op_e               op_q, op_d;
  logic [ADDR_WIDTH-1:0] index_q, index_d;
  logic [WIDTH-1:0]      data_q, data_d;
  logic                  read_enable_q, read_enable_d;
  logic [ADDR_WIDTH-1:0] read_index_q, read_index_d;
  logic                  write_enable_q, write_enable_d;
  logic [ADDR_WIDTH-1:0] write_index_q, write_index_d;
  logic                  search_enable_q, search_enable_d;
  logic [WIDTH-1:0]      search_data_q, search_data_d;
  logic [DEPTH-1:0]      entry_valid_q, entry_valid_d;
  logic                  rsp_valid_q, rsp_valid_d;
  cam_op_e               rsp_op_q, rsp_op_d;
  logic                  rsp_hit_q, rsp_hit_d;
  logic [ADDR_WIDTH-1:0] rsp_index_q, rsp_index_d;
  logic [WIDTH-1:0]      rsp_data_q, rsp_data_d;

  // Raw match lines include stale data in invalidated/never-written entries.
  logic [DEPTH-1:0]      masked_match;
  logic                  match_found;
  logic [ADDR_WIDTH-1:0] match_index;

  assign masked_match = array_match_i & entry_valid_q;

  cam_prio_enc #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_prio_enc (
    .vec_i   (masked_match),
    .found_o (match_found),
    .index_o (match_index)
  );

  always_comb begin
    state_d         = state_q;
    req_ready_d     = req_ready_q;
    op_d            = op_q;
    index_d         = index_q;
    data_d          = data_q;
    read_enable_d   = 1'b0;
    read_index_d    = read_index_q;
    write_enable_d  = 1'b0;
    write_index_d   = write_index_q;
    search_enable_d = 1'b0;
    search_data_d   = search_data_q;
    entry_valid_d   = entry_valid_q;
    rsp_valid_d     = rsp_valid_q;
    rsp_op_d        = rsp_op_q;
    rsp_hit_d       = rsp_hit_q;
    rsp_index_d     = rsp_index_q;
    rsp_data_d      = rsp_data_q;

    unique case (state_q)
      ST_IDLE: begin
        // Ready comes up one edge after reset release, then tracks IDLE.
        req_ready_d = 1'b1;
        if (req_valid_i && req_ready_q) begin
          op_d        = cam_op_e'(req_op_i);
          index_d     = req_index_i;
          data_d      = req_data_i;
          req_ready_d = 1'b0;
          state_d     = ST_ISSUE;
          // Enables are set here so they are registered high for the ISSUE cycle.
          unique case (cam_op_e'(req_op_i))
            CAM_READ: begin
              read_enable_d = 1'b1;
              read_index_d  = req_index_i;
            end
            CAM_WRITE: begin
              write_enable_d = 1'b1;
              write_index_d  = req_index_i;
              search_data_d  = req_data_i;
            end
            CAM_SEARCH: begin
              search_enable_d = 1'b1;
              search_data_d   = req_data_i;
            end
            default: ;
          endcase
        end
      end

      ST_ISSUE: begin
        state_d = ST_CAPTURE;
      end

      ST_CAPTURE: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_op_d    = op_q;
        rsp_index_d = index_q;
        rsp_data_d  = data_q;
        rsp_hit_d   = entry_valid_q[index_q];
        unique case (op_q)
          CAM_READ: begin
            rsp_data_d = array_read_data_i;
          end
          CAM_WRITE: begin
            entry_valid_d[index_q] = 1'b1;
          end
          CAM_SEARCH: begin
            rsp_hit_d   = match_found;
            rsp_index_d = match_index;
          end
          CAM_INVALIDATE: begin
            entry_valid_d[index_q] = 1'b0;
          end
          default: ;
        endcase
      end

      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q         <= ST_IDLE;
      req_ready_q     <= 1'b0;
      op_q            <= CAM_READ;
      index_q         <= '0;
      data_q          <= '0;
      read_enable_q   <= 1'b0;
      read_index_q    <= '0;
      write_enable_q  <= 1'b0;
      write_index_q   <= '0;
      search_enable_q <= 1'b0;
      search_data_q   <= '0;
      entry_valid_q   <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_op_q        <= CAM_READ;
      rsp_hit_q       <= 1'b0;
      rsp_index_q     <= '0;
      rsp_data_q      <= '0;
    end else begin
      state_q         <= state_d;
      req_ready_q     <= req_ready_d;
      op_q            <= op_d;
      index_q         <= index_d;
      data_q          <= data_d;
      read_enable_q   <= read_enable_d;
      read_index_q    <= read_index_d;
      write_enable_q  <= write_enable_d;
      write_index_q   <= write_index_d;
      search_enable_q <= search_enable_d;
      search_data_q   <= search_data_d;
      entry_valid_q   <= entry_valid_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_op_q        <= rsp_op_d;
      rsp_hit_q       <= rsp_hit_d;
      rsp_index_q     <= rsp_index_d;
      rsp_data_q      <= rsp_data_d;
    end
  end

  assign req_ready_o     = req_ready_q;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_op_o        = rsp_op_q;
  assign rsp_hit_o       = rsp_hit_q;
  assign rsp_index_o     = rsp_index_q;
  assign rsp_data_o      = rsp_data_q;
  assign read_enable_o   = read_enable_q;
  assign read_index_o    = read_index_q;
  assign write_enable_o  = write_enable_q;
  assign write_index_o   = write_index_q;
  assign search_enable_o = search_enable_q;
  assign search_data_o   = search_data_q;
  assign entry_valid_o   = entry_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_cam_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_cam_ctrl                                                     |
// | Purpose  : Self-checking bench for cam_ctrl with a behavioural CAM array   |
// |            and a reference model of entry contents and valid bits.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_cam_ctrl;
  import cam_pkg::*;

  localparam int WIDTH      = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int DEPTH      = 32;

  logic                  clk;
  logic                  rst_n;
  logic                  req_valid;
  logic                  req_ready_o;
  logic [1:0]            req_op;
  logic [ADDR_WIDTH-1:0] req_index;
  logic [WIDTH-1:0]      req_data;
  logic                  rsp_valid_o;
  logic                  rsp_ready;
  logic [1:0]            rsp_op_o;
  logic                  rsp_hit_o;
  logic [ADDR_WIDTH-1:0] rsp_index_o;
  logic [WIDTH-1:0]      rsp_data_o;
  logic                  read_enable_o;
  logic [ADDR_WIDTH-1:0] read_index_o;
  logic                  write_enable_o;
  logic [ADDR_WIDTH-1:0] write_index_o;
  logic                  search_enable_o;
  logic [WIDTH-1:0]      search_data_o;
  logic [WIDTH-1:0]      arr_rd;
  logic [DEPTH-1:0]      arr_match;
  logic [DEPTH-1:0]      entry_valid_o;

  cam_ctrl #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) dut (
    .clk_i             (clk),
    .rst_n_i           (rst_n),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready_o),
    .req_op_i          (req_op),
    .req_index_i       (req_index),
    .req_data_i        (req_data),
    .rsp_valid_o       (rsp_valid_o),
    .rsp_ready_i       (rsp_ready),
    .rsp_op_o          (rsp_op_o),
    .rsp_hit_o         (rsp_hit_o),
    .rsp_index_o       (rsp_index_o),
    .rsp_data_o        (rsp_data_o),
    .read_enable_o     (read_enable_o),
    .read_index_o      (read_index_o),
    .write_enable_o    (write_enable_o),
    .write_index_o     (write_index_o),
    .search_enable_o   (search_enable_o),
    .search_data_o     (search_data_o),
    .array_read_data_i (arr_rd),
    .array_match_i     (arr_match),
    .entry_valid_o     (entry_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural CAM array: registered read data and match lines, one cycle
  // after the corresponding enable. force_en overrides the match lines.
  logic [WIDTH-1:0] arr_mem [DEPTH] = '{default: '0};
  bit               force_en  = 1'b0;
  logic [DEPTH-1:0] force_pat = '0;

  initial begin
    arr_rd    = '0;
    arr_match = '0;
  end

  always @(posedge clk) begin
    if (write_enable_o) arr_mem[write_index_o] <= search_data_o;
    if (read_enable_o)  arr_rd <= arr_mem[read_index_o];
    if (search_enable_o) begin
      for (int i = 0; i < DEPTH; i++)
        arr_match[i] <= force_en ? force_pat[i] : (arr_mem[i] == search_data_o);
    end
  end

  // Reference model state
  logic [WIDTH-1:0] ref_mem [DEPTH] = '{default: '0};
  logic [DEPTH-1:0] ref_valid = '0;

  logic [1:0]            e_op;
  logic                  e_hit;
  logic [ADDR_WIDTH-1:0] e_idx;
  logic [WIDTH-1:0]      e_data;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic logic [2:0] ens();
    return {read_enable_o, write_enable_o, search_enable_o};
  endfunction

  // Present a command, wait for acceptance, check the issue pulse and
  // the response arriving on the third cycle after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [ADDR_WIDTH-1:0] idx,
                       input logic [WIDTH-1:0] d);
    logic [DEPTH-1:0] raw;
    logic [DEPTH-1:0] masked;
    logic [2:0]       exp_en;
    int               n;
    req_valid = 1'b1; req_op = op; req_index = idx; req_data = d;
    n = 0;
    while (!req_ready_o && n < 12) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready_o) begin
      chk("accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    // Scramble request fields: op/index/data must only be sampled at acceptance.
    req_valid = 1'b0;
    req_op    = 2'($urandom);
    req_index = ADDR_WIDTH'($urandom);
    req_data  = $urandom;

    e_op = op; e_idx = idx; e_data = d; e_hit = ref_valid[idx];
    exp_en = 3'b000;
    case (op)
      2'd0: begin
        exp_en = 3'b100;
        e_data = ref_mem[idx];
      end
      2'd1: begin
        exp_en = 3'b010;
        ref_valid[idx] = 1'b1;
        ref_mem[idx]   = d;
      end
      2'd2: begin
        exp_en = 3'b001;
        for (int i = 0; i < DEPTH; i++) raw[i] = force_en ? force_pat[i] : (ref_mem[i] == d);
        masked = raw & ref_valid;
        e_hit  = |masked;
        e_idx  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) if (masked[i]) e_idx = ADDR_WIDTH'(i);
      end
      default: ref_valid[idx] = 1'b0;
    endcase

    chk("issue_enables", ens(), exp_en);
    if (op == 2'd0) chk("read_index", read_index_o, idx);
    if (op == 2'd1) begin
      chk("write_index", write_index_o, idx);
      chk("write_data", search_data_o, d);
    end
    if (op == 2'd2) chk("search_key", search_data_o, d);

    @(negedge clk);
    chk("capture_enables", ens(), 0);
    chk("capture_rsp_valid", rsp_valid_o, 0);

    @(negedge clk);
    chk("rsp_valid", rsp_valid_o, 1);
    chk("rsp_op", rsp_op_o, e_op);
    chk("rsp_hit", rsp_hit_o, e_hit);
    chk("rsp_index", rsp_index_o, e_idx);
    chk("rsp_data", rsp_data_o, e_data);
  endtask

  // Hold the response for `hold` cycles (optionally with the next request
  // already presented), then handshake it.
  task automatic finish(input int hold, input bit chain, input logic [1:0] nop,
                        input logic [ADDR_WIDTH-1:0] nidx, input logic [WIDTH-1:0] ndata);
    if (chain) begin
      req_valid = 1'b1; req_op = nop; req_index = nidx; req_data = ndata;
    end
    rsp_ready = 1'b0;
    for (int k = 0; k < hold; k++) begin
      chk("hold_rsp_valid", rsp_valid_o, 1);
      chk("hold_rsp_stable", {rsp_op_o, rsp_hit_o, rsp_index_o, rsp_data_o},
          {e_op, e_hit, e_idx, e_data});
      chk("hold_req_ready", req_ready_o, 0);
      chk("hold_no_enables", ens(), 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_rsp_valid", rsp_valid_o, 0);
    chk("post_req_ready", req_ready_o, 1);
    chk("entry_valid", entry_valid_o, ref_valid);
  endtask

  logic [1:0]            n_op;
  logic [ADDR_WIDTH-1:0] n_idx;
  logic [WIDTH-1:0]      n_data;
  bit                    n_force;
  logic [DEPTH-1:0]      n_pat;

  task automatic gen();
    n_op    = 2'($urandom);
    n_idx   = ($urandom_range(0, 3) == 0) ? ADDR_WIDTH'(DEPTH - 1) : ADDR_WIDTH'($urandom_range(0, 7));
    n_data  = ($urandom_range(0, 7) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 3));
    n_force = ($urandom_range(0, 3) == 0);
    n_pat   = DEPTH'($urandom);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_index = '0; req_data = '0;
    rsp_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_enables", ens(), 0);
    chk("rst_entry_valid", entry_valid_o, 0);
    chk("rst_rsp_fields", {rsp_op_o, rsp_hit_o, rsp_index_o, rsp_data_o}, 0);
    chk("rst_dec_fields", {read_index_o, write_index_o, search_data_o}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rel_req_ready", req_ready_o, 1);

    // Directed sequence
    issue(2'd1, 5'd5, 32'hDEADBEEF); chk("wr5_hit0", rsp_hit_o, 0); finish(0, 0, 0, 0, 0);
    chk("wr5_valid", entry_valid_o[5], 1);
    issue(2'd1, 5'd5, 32'hDEADBEEF); chk("wr5_again_hit", rsp_hit_o, 1); finish(1, 0, 0, 0, 0);
    issue(2'd0, 5'd5, 32'h0);        chk("rd5_data", rsp_data_o, 32'hDEADBEEF); finish(0, 0, 0, 0, 0);
    issue(2'd0, 5'd31, 32'h0);       chk("rd31_hit", rsp_hit_o, 0); finish(0, 0, 0, 0, 0);
    issue(2'd1, 5'd9, 32'h000000A5); finish(0, 0, 0, 0, 0);
    issue(2'd1, 5'd31, 32'h000000A5); finish(0, 0, 0, 0, 0);
    issue(2'd3, 5'd5, 32'h0);        finish(0, 0, 0, 0, 0);
    force_en = 1'b1;
    force_pat = (32'h1 << 3) | (32'h1 << 9) | (32'h1 << 31);
    issue(2'd2, 5'd0, 32'h000000A5); chk("search_idx9", rsp_index_o, 9); finish(0, 0, 0, 0, 0);
    issue(2'd3, 5'd9, 32'h0);        chk("inv9_hit", rsp_hit_o, 1); finish(0, 0, 0, 0, 0);
    chk("inv9_valid", entry_valid_o[9], 0);
    issue(2'd2, 5'd0, 32'h000000A5); chk("search_idx31", rsp_index_o, 31);
    // Backpressure with the next request held throughout
    finish(5, 1, 2'd0, 5'd31, 32'h0);
    issue(2'd0, 5'd31, 32'h0);       finish(0, 0, 0, 0, 0);
    force_en = 1'b0;

    // Randomized traffic
    gen();
    for (int i = 0; i < 150; i++) begin
      logic [1:0]            c_op;
      logic [ADDR_WIDTH-1:0] c_idx;
      logic [WIDTH-1:0]      c_data;
      c_op = n_op; c_idx = n_idx; c_data = n_data;
      force_en = n_force; force_pat = n_pat;
      issue(c_op, c_idx, c_data);
      gen();
      finish($urandom_range(0, 3), 1'($urandom), n_op, n_idx, n_data);
    end
    force_en = 1'b0;
    req_valid = 1'b0;

    // Reset during ISSUE aborts with no response and no further enables
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd1; req_index = 5'd7; req_data = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_issue_we", write_enable_o, 1);
    rst_n = 1'b0; req_valid = 1'b0;
    #1;
    chk("midrst_enables", ens(), 0);
    chk("midrst_rsp_valid", rsp_valid_o, 0);
    chk("midrst_entry_valid", entry_valid_o, 0);
    ref_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("after_rst_rsp_valid", rsp_valid_o, 0);
      chk("after_rst_enables", ens(), 0);
    end

    // Search with every raw match on an invalid entry
    force_en = 1'b1;
    force_pat = (32'h1 << 3) | (32'h1 << 9) | (32'h1 << 31);
    issue(2'd2, 5'd0, 32'h000000A5);
    chk("allinv_hit", rsp_hit_o, 0);
    chk("allinv_idx", rsp_index_o, 0);
    finish(0, 0, 0, 0, 0);
    force_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
